// File: rtl/lcd_bus_driver.sv
// HD44780 bus-cycle engine: runs the power-on init sequence, then turns single
// CPU byte writes into timed RS/data setup, E pulse, hold and execution wait.
module lcd_bus_driver #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_E_HIGH  = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_LONG    = 82000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       clr_ovr,
  output logic       busy,
  output logic       overrun,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned IDX_W   = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(5);

  // Counter load values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_LONG - 1);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_INIT    = 3'd1,
    S_IDLE    = 3'd2,
    S_SETUP   = 3'd3,
    S_EHIGH   = 3'd4,
    S_HOLD    = 3'd5,
    S_WAIT    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               init_q, init_d;
  logic               long_q, long_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic               rs_q, rs_d;
  logic               e_q, e_d;
  logic [7:0]         data_q, data_d;
  logic               cnt_zero;

  // Power-on command table: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
      3'd3:             init_cmd = 8'h0C;
      3'd4:             init_cmd = 8'h01;
      3'd5:             init_cmd = 8'h06;
      default:          init_cmd = 8'h00;
    endcase
  endfunction

  assign cnt_zero = (cnt_q == '0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_POWERUP;
      cnt_q   <= PWR_LD;
      idx_q   <= '0;
      init_q  <= 1'b1;
      long_q  <= 1'b0;
      busy_q  <= 1'b1;
      ovr_q   <= 1'b0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
      long_q  <= long_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      data_q  <= data_d;
    end
  end

  // Next-state, counter, init index and wait-length selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    init_d  = init_q;
    long_d  = long_q;
    case (state_q)
      S_POWERUP: begin
        if (cnt_zero) state_d = S_INIT;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_INIT: begin
        state_d = S_SETUP;
        cnt_d   = SETUP_LD;
        long_d  = (idx_q == IDX_W'(0)) || (idx_q == IDX_W'(4));
      end
      S_IDLE: begin
        if (wr_en) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          // Clear (0x01) and home (0x02/0x03) need the long execution wait.
          long_d  = !wr_rs && (wr_data[7:2] == 6'd0) && (wr_data != 8'h00);
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_EHIGH;
          cnt_d   = EHIGH_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EHIGH: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_WAIT;
          cnt_d   = long_q ? LONG_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (init_q && (idx_q < IDX_LAST)) begin
          state_d = S_INIT;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          state_d = S_IDLE;
          init_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_POWERUP;
        cnt_d   = PWR_LD;
        idx_d   = '0;
        init_d  = 1'b1;
      end
    endcase
  end

  // Registered output values, derived from the upcoming state
  always_comb begin
    busy_d = (state_d != S_IDLE);
    e_d    = (state_d == S_EHIGH);
    rs_d   = rs_q;
    data_d = data_q;
    ovr_d  = ovr_q;
    // RS/data only ever change on entry to SETUP.
    if (state_q == S_INIT) begin
      rs_d   = 1'b0;
      data_d = init_cmd(idx_q);
    end else if ((state_q == S_IDLE) && wr_en) begin
      rs_d   = wr_rs;
      data_d = wr_data;
    end
    // A dropped write beats a coincident clear.
    if (wr_en && (state_q != S_IDLE)) ovr_d = 1'b1;
    else if (clr_ovr)                 ovr_d = 1'b0;
  end

  assign busy     = busy_q;
  assign overrun  = ovr_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_data = data_q;

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Downstream consumer of the memory-mapped LCD port. It turns single CPU byte writes into correctly timed HD44780 bus cycles: RS/data setup, enable pulse, hold, and post-command execution wait. It also runs the power-on initialisation sequence autonomously and exposes `busy`/`overrun` for the bus status read. Software no longer bit-bangs the enable line.

## Interface

Parameters (all counts are in clk cycles):
- `T_POWERUP`, 750000: wait from reset release before the first init command.
- `T_SETUP`, 2: RS/data stable before E rises.
- `T_E_HIGH`, 12: E high width.
- `T_HOLD`, 2: RS/data held after E falls.
- `T_CMD`, 2000: execution wait for normal commands and data.
- `T_LONG`, 82000: execution wait for clear/home and for the first init command.
- `CNT_W`, 20: delay counter width. It must hold the largest parameter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `wr_en` in 1: one-cycle write request from the bus decode.
- `wr_rs` in 1: register select for the request (0 = command, 1 = data).
- `wr_data` in 8: byte for the request.
- `clr_ovr` in 1: clears `overrun`.
- `busy` out 1: high while a sequence is in progress. Writes are accepted only when `busy` is low.
- `overrun` out 1: sticky; set when `wr_en` arrives while `busy`.
- `lcd_rs` out 1: LCD RS pin.
- `lcd_rw` out 1: LCD RW pin. Constant 0.
- `lcd_e` out 1: LCD enable pin.
- `lcd_data` out 8: LCD DB7..DB0.

## Operation

States: POWERUP, INIT, IDLE, SETUP, EHIGH, HOLD, WAIT.

- There is one down-counter (`CNT_W` bits) and a 3-bit init index (0..5).
- **Reset values:** state POWERUP, counter = `T_POWERUP`-1, `busy` 1, `overrun` 0, `lcd_e` 0, `lcd_rs` 0, `lcd_data` 0x00, index 0.
- **POWERUP:** counts down. At 0 it goes to INIT.
- **INIT:** loads the index-th command onto `lcd_rs`=0 / `lcd_data`, then enters SETUP. The command table is 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - Waits: index 0 and index 4 use `T_LONG`; all others use `T_CMD`.
  - After WAIT, if index < 5 the index increments and the block returns to INIT. Otherwise it goes to IDLE.
- **IDLE:** `busy`=0. When `wr_en`=1:
  - latch `wr_rs` into `lcd_rs` and `wr_data` into `lcd_data`;
  - select the wait: `T_LONG` if `wr_rs`=0, `wr_data[7:2]`=0 and `wr_data`≠0; else `T_CMD`;
  - go to SETUP.
- **SETUP:** lasts `T_SETUP` cycles, then EHIGH.
- **EHIGH:** `lcd_e`=1 for `T_E_HIGH` cycles, then HOLD.
- **HOLD:** lasts `T_HOLD` cycles, then WAIT.
- **WAIT:** lasts the selected wait length, then IDLE (or INIT during the init sequence).
- `lcd_rs` and `lcd_data` change only on the transition into SETUP. They are otherwise held, including while in IDLE.
- **Dropped writes:** `wr_en`=1 in any state other than IDLE sets `overrun` and the write is discarded. Nothing is queued.
- **`clr_ovr`:** clears `overrun`. If `clr_ovr` and a dropped write occur in the same cycle, set wins.
- **Reset mid-sequence:** `lcd_e` drops to 0 on the next edge and the full power-up and init sequence restarts.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- A write is accepted at edge A, the edge where state is IDLE and `wr_en`=1.
  - `busy`=1 and the new `lcd_rs`/`lcd_data` are visible from A.
  - `lcd_e` rises at A+`T_SETUP`.
  - `lcd_e` falls at A+`T_SETUP`+`T_E_HIGH`.
  - `busy` falls at A+`T_SETUP`+`T_E_HIGH`+`T_HOLD`+wait.
- A new write is therefore accepted no earlier than the edge at which `busy` is first seen low.
- Each phase of length N occupies exactly N cycles. All parameters must be ≥1.
- Init total: `busy` stays high from reset release for `T_POWERUP` + 6·(1+`T_SETUP`+`T_E_HIGH`+`T_HOLD`) + 2·`T_LONG` + 4·`T_CMD` cycles. The extra 1 per command is the INIT load cycle.

## Test plan

Directed scenarios. Use sim parameters `T_POWERUP`=100, `T_SETUP`=2, `T_E_HIGH`=4, `T_HOLD`=2, `T_CMD`=20, `T_LONG`=50.

- **Reset then idle:** `busy` is 1 for exactly 100+6·9+100+80 = 334 cycles. Exactly six E pulses occur, each 4 cycles wide, carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with `lcd_rs`=0.
- **Data write:** after init, `wr_en` with rs=1, data=0x41.
  - `lcd_data`=0x41 and `lcd_rs`=1 from the accept edge.
  - E is high on cycles +2..+5.
  - `busy` is low again 28 cycles after accept.
- **Clear command:** rs=0, data=0x01 gives `busy` for 58 cycles. Data=0x80 gives `busy` for 28 cycles.
- **Overrun:** `wr_en` while `busy`.
  - `overrun` goes to 1 and `lcd_data` is unchanged.
  - The in-flight E pulse completes normally.
  - `clr_ovr` then gives `overrun`=0. `clr_ovr` coincident with a dropped write gives `overrun`=1.
- **Reset during EHIGH:** `lcd_e`=0 the next cycle, `busy`=1, and the full 334-cycle init sequence repeats.
- **Back-to-back writes:** issue `wr_en` on the first cycle `busy` is seen low. It is accepted with no `overrun`.
